// File: rtl/sap_datapath.sv
// SAP-1 style datapath: PC, MAR, IR, A, B, carry, halt flag, a 16x8 RAM
// and a single shared 8-bit bus. The external controller sequences the
// datapath through a 14-bit control word. While the block is halted or
// held in reset, the program-load port can write the RAM.
module sap_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] ctrl,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [3:0]  opcode,
    output logic [7:0]  bus,
    output logic [7:0]  a_out,
    output logic [3:0]  pc_out,
    output logic        carry,
    output logic        halted,
    output logic        bus_conflict
);

    // Control word fields
    logic hlt, pc_inc, pc_load, pc_en, mar_load, mem_st, mem_en;
    logic ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en;

    assign hlt       = ctrl[13];
    assign pc_inc    = ctrl[12];
    assign pc_load   = ctrl[11];
    assign pc_en     = ctrl[10];
    assign mar_load  = ctrl[9];
    assign mem_st    = ctrl[8];
    assign mem_en    = ctrl[7];
    assign ir_load   = ctrl[6];
    assign ir_en     = ctrl[5];
    assign a_load    = ctrl[4];
    assign a_en      = ctrl[3];
    assign b_load    = ctrl[2];
    assign adder_sub = ctrl[1];
    assign adder_en  = ctrl[0];

    // Architectural state
    logic [3:0] pc_q,  pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q,  ir_d;
    logic [7:0] a_q,   a_d;
    logic [7:0] b_q,   b_d;
    logic       carry_q,  carry_d;
    logic       halted_q, halted_d;

    // Program RAM; intentionally has no reset so a loaded program survives rst
    logic [7:0] ram_q [16];
    logic [7:0] ram_rd;

    // RAM write port selection
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       prog_ok;

    // ALU
    logic [8:0] alu_sum;
    logic [7:0] alu_b;
    logic [2:0] drv_cnt;

    assign ram_rd = ram_q[mar_q];

    // Adder/subtractor: subtract is A + ~B + 1, bit 8 is carry (1 = no borrow)
    always_comb begin
        alu_b   = adder_sub ? ~b_q : b_q;
        alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {8'h00, adder_sub};
    end

    // Bus mux: later assignments override earlier ones, giving the fixed
    // priority adder > A > IR > RAM > PC; nobody driving reads as zero
    always_comb begin
        bus = 8'h00;
        if (pc_en)    bus = {4'h0, pc_q};
        if (mem_en)   bus = ram_rd;
        if (ir_en)    bus = {4'h0, ir_q[3:0]};
        if (a_en)     bus = a_q;
        if (adder_en) bus = alu_sum[7:0];
    end

    // Flag any cycle where two or more drivers contend for the bus
    always_comb begin
        drv_cnt = {2'b00, pc_en} + {2'b00, mem_en} + {2'b00, ir_en}
                + {2'b00, a_en}  + {2'b00, adder_en};
        bus_conflict = (drv_cnt > 3'd1);
    end

    // Next-state for all registers; halted freezes everything but the halt flag
    always_comb begin
        pc_d     = pc_q;
        mar_d    = mar_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        halted_d = halted_q | hlt;
        if (!halted_q) begin
            if (mar_load) mar_d = bus[3:0];
            if (ir_load)  ir_d  = bus;
            if (a_load)   a_d   = bus;
            if (b_load)   b_d   = bus;
            // load beats increment when both are asserted
            if (pc_load)     pc_d = bus[3:0];
            else if (pc_inc) pc_d = pc_q + 4'd1;
            // carry is committed only together with an ALU result landing in A
            if (adder_en && a_load) carry_d = alu_sum[8];
        end
    end

    // State registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= 4'h0;
            mar_q    <= 4'h0;
            ir_q     <= 8'h00;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    // RAM write source: the program port owns the RAM while stopped,
    // the datapath owns it while running
    always_comb begin
        prog_ok   = halted_q | ~rst;
        ram_we    = 1'b0;
        ram_waddr = mar_q;
        ram_wdata = bus;
        if (prog_ok) begin
            if (prog_we) begin
                ram_we    = 1'b1;
                ram_waddr = prog_addr;
                ram_wdata = prog_data;
            end
        end else if (mem_st) begin
            ram_we = 1'b1;
        end
    end

    // RAM storage
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign opcode = ir_q[7:4];
    assign a_out  = a_q;
    assign pc_out = pc_q;
    assign carry  = carry_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Bench for sap_datapath: expected values are queued as stimulus is
// driven and popped/compared when the DUT output is sampled.
module tb_sap_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] ctrl = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [7:0]  a_out;
    logic [3:0]  pc_out;
    logic        carry;
    logic        halted;
    logic        bus_conflict;

    localparam logic [13:0] HLT = 14'h2000, PC_INC = 14'h1000, PC_LOAD = 14'h0800,
                            PC_EN = 14'h0400, MAR_LOAD = 14'h0200, MEM_ST = 14'h0100,
                            MEM_EN = 14'h0080, IR_LOAD = 14'h0040, IR_EN = 14'h0020,
                            A_LOAD = 14'h0010, A_EN = 14'h0008, B_LOAD = 14'h0004,
                            ADD_SUB = 14'h0002, ADD_EN = 14'h0001;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } exp_t;

    exp_t       expq[$];
    exp_t       e;
    logic [7:0] got;
    int         total = 0;
    int         bad = 0;

    sap_datapath dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .opcode(opcode), .bus(bus), .a_out(a_out), .pc_out(pc_out),
        .carry(carry), .halted(halted), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic sb_push(input string n, input logic [7:0] v);
        exp_t t;
        t.nm = n;
        t.v  = v;
        expq.push_back(t);
    endtask

    // one clock with control word c, inputs change 1ns after the edge
    task automatic step(input logic [13:0] c);
        ctrl = c;
        @(posedge clk);
        #1;
        ctrl = '0;
    endtask

    // apply c combinationally and let the bus settle (no clock)
    task automatic drive(input logic [13:0] c);
        ctrl = c;
        #1;
    endtask

    task automatic set_pc(input logic [3:0] k);
        for (int i = 0; i < 16 && pc_out != k; i++) step(PC_INC);
    endtask

    task automatic set_mar(input logic [3:0] k);
        set_pc(k);
        step(PC_EN | MAR_LOAD);
    endtask

    task automatic prog_write(input logic [3:0] ad, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = ad; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        prog_write(4'd0, 8'h0E);  prog_write(4'd14, 8'h05);
        prog_write(4'd1, 8'hF0);  prog_write(4'd2, 8'h20);
        prog_write(4'd3, 8'h05);  prog_write(4'd4, 8'h07);
        prog_write(4'd5, 8'h3C);  prog_write(4'd6, 8'h47);
        prog_write(4'd7, 8'h02);  prog_write(4'd8, 8'hAA);
        prog_write(4'd9, 8'h00);  prog_write(4'd13, 8'h11);
        drive(14'h0);
        sb_push("rst_pc", 8'h00); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("rst_a", 8'h00); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("rst_flags", 8'h00); got = {5'h0, carry, halted, bus_conflict};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("rst_bus", 8'h00); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        step(PC_EN | MAR_LOAD);
        step(PC_INC);
        step(MEM_EN | IR_LOAD);
        sb_push("fetch_pc", 8'h01); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("fetch_opcode", 8'h00); got = {4'h0, opcode};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("fetch_ir_lo", 8'h0E); drive(IR_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("fetch_mar0", 8'h0E); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
    endtask

    task automatic test_prog_load();
        prog_we = 1'b1; prog_addr = 4'd13; prog_data = 8'h99;
        step(14'h0);
        prog_we = 1'b0;
        set_mar(4'd14);
        sb_push("prog_rd14", 8'h05); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        set_mar(4'd13);
        sb_push("prog_we_ignored", 8'h11); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
    endtask

    task automatic test_arith();
        set_mar(4'd1); step(MEM_EN | A_LOAD);
        set_mar(4'd2); step(MEM_EN | B_LOAD);
        sb_push("add_bus", 8'h10); drive(ADD_EN | A_LOAD); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(ADD_EN | A_LOAD);
        sb_push("add_a", 8'h10); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("add_carry", 8'h01); got = {7'h0, carry};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        set_mar(4'd3); step(MEM_EN | A_LOAD);
        set_mar(4'd4); step(MEM_EN | B_LOAD);
        step(ADD_SUB | ADD_EN | A_LOAD);
        sb_push("sub_a", 8'hFE); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("sub_borrow", 8'h00); got = {7'h0, carry};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        // FE+07 overflows but lands in B, so carry must not move
        step(ADD_EN | B_LOAD);
        sb_push("carry_hold", 8'h00); got = {7'h0, carry};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("b_from_alu", 8'hF9); drive(ADD_EN | ADD_SUB); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
    endtask

    task automatic test_store_jump();
        set_mar(4'd5); step(MEM_EN | A_LOAD);
        set_mar(4'd9);
        step(A_EN | MEM_ST);
        sb_push("store_ram9", 8'h3C); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        set_mar(4'd6); step(MEM_EN | IR_LOAD);
        sb_push("ir_opcode", 8'h04); got = {4'h0, opcode};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(IR_EN | PC_LOAD);
        sb_push("jump_pc", 8'h07); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(PC_EN | MAR_LOAD);
        step(MEM_EN | PC_INC | PC_LOAD);
        sb_push("load_over_inc", 8'h02); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        set_pc(4'hF);
        step(PC_INC);
        sb_push("pc_wrap", 8'h00); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
    endtask

    task automatic test_conflict();
        // A=3C, B=05, PC=0, IR=47
        drive(A_EN | PC_EN);
        sb_push("conf_bus", 8'h3C); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("conf_flag", 8'h01); got = {7'h0, bus_conflict};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(14'h0);
        sb_push("idle_bus", 8'h00); got = {bus[6:0], bus_conflict} | {7'h0, bus[7]};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(ADD_EN | A_EN | IR_EN);
        sb_push("adder_prio", 8'h41); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(IR_EN);
        sb_push("single_drv", 8'h07); got = bus_conflict ? 8'hFF : bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(14'h0);
    endtask

    task automatic test_back_to_back();
        step(A_EN | A_LOAD);
        sb_push("a_self_load", 8'h3C); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("b2b_1", 8'h41);
        sb_push("b2b_2", 8'h46);
        step(ADD_EN | A_LOAD); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(ADD_EN | A_LOAD); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
    endtask

    task automatic test_halt();
        set_mar(4'd8);
        step(HLT);
        sb_push("halted_set", 8'h01); got = {7'h0, halted};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        sb_push("halt_bus_live", 8'hAA); drive(MEM_EN | A_LOAD); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(MEM_EN | A_LOAD);
        sb_push("halt_a_frozen", 8'h46); got = a_out;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        step(PC_INC);
        sb_push("halt_pc_frozen", 8'h08); got = {4'h0, pc_out};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        prog_write(4'd8, 8'h55);
        sb_push("halt_prog_we", 8'h55); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(14'h0);
        rst = 1'b0;
        #1;
        sb_push("rst_clears", 8'h00); got = {a_out[6:0], halted} | {7'h0, a_out[7]};
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        @(posedge clk); #1;
        rst = 1'b1;
        set_mar(4'd9);
        sb_push("ram_persists", 8'h3C); drive(MEM_EN); got = bus;
        e = expq.pop_front(); total++; if (got !== e.v) begin bad++; $display("FAIL %s got=%h exp=%h", e.nm, got, e.v); end
        drive(14'h0);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_prog_load();
        test_arith();
        test_store_jump();
        test_conflict();
        test_back_to_back();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_datapath.md
SAP_DATAPATH -- requirements
Module: sap_datapath

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: ctrl  input  14  control word: [13] hlt, [12] pc_inc, [11] pc_load, [10] pc_en, [9] mar_load, [8] mem_st, [7] mem_en, [6] ir_load, [5] ir_en, [4] a_load, [3] a_en, [2] b_load, [1] adder_sub, [0] adder_en.
REQ-004 SHALL have port: prog_we  input  1  program-load write strobe.
REQ-005 SHALL have port: prog_addr  input  4  program-load address.
REQ-006 SHALL have port: prog_data  input  8  program-load data.
REQ-007 SHALL have port: opcode  output  4  IR[7:4], fed back to the controller.
REQ-008 SHALL have port: bus  output  8  current internal bus value.
REQ-009 SHALL have port: a_out  output  8  accumulator A.
REQ-010 SHALL have port: pc_out  output  4  program counter.
REQ-011 SHALL have port: carry  output  1  carry/borrow flag from the last committed ALU result.
REQ-012 SHALL have port: halted  output  1  sticky halt indicator.
REQ-013 SHALL have port: bus_conflict  output  1  combinational; high when more than one bus driver is enabled.

Function
REQ-014 SHALL hold registers PC[3:0], MAR[3:0], IR[7:0], A[7:0], B[7:0], carry, halted, and a 16x8 RAM.
REQ-015 SHALL form the bus combinationally with drivers pc_en -> {4'h0,PC}, mem_en -> RAM[MAR], ir_en -> {4'h0,IR[3:0]}, a_en -> A, adder_en -> ALU result; with no driver enabled, bus = 8'h00.
REQ-016 SHALL resolve multiple enabled drivers by fixed priority adder_en > a_en > ir_en > mem_en > pc_en and assert bus_conflict for the same cycle.
REQ-017 SHALL compute the ALU as a 9-bit result: adder_sub=0 -> A+B, adder_sub=1 -> A+~B+1; result = bits[7:0], carry_next = bit[8] (for subtract, 1 = no borrow).
REQ-018 SHALL on each rising edge while not halted: mar_load -> MAR<=bus[3:0]; ir_load -> IR<=bus; a_load -> A<=bus; b_load -> B<=bus; mem_st -> RAM[MAR]<=bus (MAR value before the edge).
REQ-019 SHALL update PC as: pc_load -> PC<=bus[3:0]; else pc_inc -> PC<=PC+1 wrapping 4'hF->4'h0; pc_load wins when both are asserted.
REQ-020 SHALL update carry only on edges where adder_en and a_load are both high and the block is not halted.
REQ-021 SHALL set halted on the first rising edge with ctrl[13] high; halted stays 1 until reset.
REQ-022 SHALL, while halted, block all register and RAM updates from ctrl; bus and bus_conflict remain combinationally live.
REQ-023 SHALL, while halted or rst low, write RAM[prog_addr]<=prog_data on rising edges with prog_we high; prog_we is ignored while running.
REQ-024 SHALL let a register both drive and load the bus in one cycle (e.g. A drive + A load) and capture the pre-edge bus value, with no combinational loop.
REQ-025 SHALL present opcode = IR[7:4] continuously.

Reset
REQ-026 SHALL, while rst is low, force PC, MAR, IR, A, B, carry, halted to 0 asynchronously; RAM contents are not cleared.
REQ-027 SHALL, when rst is asserted mid-instruction, discard any in-flight effect; RAM writes already committed persist.
REQ-028 SHALL resume normal update on the first rising edge after rst deasserts.

Verification
REQ-029 Program load: rst low, prog_we writes RAM[0]=8'h0E, RAM[14]=8'h05 -> after release, readback via mar_load+mem_en shows bus=8'h05 at MAR=14.
REQ-030 Fetch: PC=0, sequence pc_en+mar_load, pc_inc, mem_en+ir_load -> MAR=0, PC=1, IR=8'h0E, opcode=4'h0.
REQ-031 Arithmetic: A=8'hF0, B=8'h20, adder_en+a_load -> A=8'h10, carry=1; A=8'h05, B=8'h07, adder_sub+adder_en+a_load -> A=8'hFE, carry=0.
REQ-032 Store/jump: A=8'h3C, MAR=9, a_en+mem_st -> RAM[9]=8'h3C; ir_en+pc_load with IR=8'h47 -> PC=7; pc_inc+pc_load with bus=8'h02 -> PC=2; PC=4'hF with pc_inc -> PC=0.
REQ-033 Halt: ctrl[13] one cycle, then a_load with bus=8'hAA -> halted=1, A unchanged; prog_we now accepted; rst low -> halted=0, A=0.
REQ-034 Conflict: a_en+pc_en together -> bus=A, bus_conflict=1; no driver -> bus=8'h00, bus_conflict=0.
